game_director: RTL and testbench

//  Parametrised game-state and video-composition core for Chip Invaders. It is the successor to the hard-wired

---
 rtl/game_director_pkg.sv | 30 +++
 rtl/game_director_if.sv | 47 ++++
 rtl/game_director_mixer.sv | 51 +++++
 rtl/game_director.sv | 147 ++++++++++++++
 tb/tb_game_director.sv | 300 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/game_director_pkg.sv
// Shared types and constants for the Chip Invaders game director.
package game_director_pkg;

  typedef enum logic [1:0] {
    ATTRACT   = 2'd0,
    PLAYING   = 2'd1,
    HIT_PAUSE = 2'd2,
    GAME_OVER = 2'd3
  } game_state_t;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb12_t;

  localparam rgb12_t CLR_BLACK   = 12'h000;
  localparam rgb12_t CLR_GREEN   = 12'h0F0;
  localparam rgb12_t CLR_MAGENTA = 12'hF0F;
  localparam rgb12_t CLR_WHITE   = 12'hFFF;
  localparam rgb12_t CLR_RED     = 12'hF00;

  // Layer 0 (player cannon) sits in the LSBs.
  localparam logic [4*12-1:0] DEFAULT_LAYER_RGB = {CLR_RED, CLR_WHITE, CLR_MAGENTA, CLR_GREEN};

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/game_director_if.sv
// Bundle of game events, video inputs and game/VGA outputs around game_director.
interface game_director_if
  import game_director_pkg::*;
#(
  parameter int N_LAYERS = 4,
  parameter int LIVES_W  = 2,
  parameter int SCORE_W  = 8,
  parameter int WAVE_W   = 4
) ();

  logic                hsync_in;
  logic                vsync_in;
  logic                display_on;
  logic [N_LAYERS-1:0] layer_on;
  logic                btn_start;
  logic                alien_hit;
  logic [7:0]          hit_points;
  logic                player_hit;
  logic                wave_cleared;

  game_state_t         state;
  logic                play_en;
  logic                frame_tick;
  logic [LIVES_W-1:0]  lives;
  logic [SCORE_W-1:0]  score;
  logic [WAVE_W-1:0]   wave;
  logic [3:0]          vga_r;
  logic [3:0]          vga_g;
  logic [3:0]          vga_b;
  logic                vga_hs;
  logic                vga_vs;

  modport master (
    output hsync_in, vsync_in, display_on, layer_on, btn_start,
           alien_hit, hit_points, player_hit, wave_cleared,
    input  state, play_en, frame_tick, lives, score, wave,
           vga_r, vga_g, vga_b, vga_hs, vga_vs
  );

  modport slave (
    input  hsync_in, vsync_in, display_on, layer_on, btn_start,
           alien_hit, hit_points, player_hit, wave_cleared,
    output state, play_en, frame_tick, lives, score, wave,
           vga_r, vga_g, vga_b, vga_hs, vga_vs
  );

endinterface

// File: rtl/game_director_mixer.sv
// Priority sprite compositor: lowest-index active layer wins, layer 0 can be
// blanked for the hit-pause blink, and colour is registered together with the
// syncs so they leave on the same clock.
module layer_mixer
  import game_director_pkg::*;
#(
  parameter int                       N_LAYERS  = 4,
  parameter logic [N_LAYERS*12-1:0]   LAYER_RGB = {N_LAYERS{12'hFFF}},
  parameter rgb12_t                   BG_RGB    = CLR_BLACK,
  parameter logic                     SYNC_IDLE = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                display_on,
  input  logic [N_LAYERS-1:0] layer_on,
  input  logic                mask_top,
  input  logic                hsync_in,
  input  logic                vsync_in,
  output rgb12_t              rgb,
  output logic                hs,
  output logic                vs
);

  logic [N_LAYERS-1:0] layer_eff;
  rgb12_t              pick;

  // Pick the colour of the highest-priority visible layer for this pixel.
  always_comb begin
    layer_eff    = layer_on;
    layer_eff[0] = layer_on[0] & ~mask_top;
    pick         = BG_RGB;
    for (int i = N_LAYERS - 1; i >= 0; i--) begin
      if (layer_eff[i]) pick = LAYER_RGB[i*12 +: 12];
    end
    if (!display_on) pick = CLR_BLACK;
  end

  // Register colour and syncs in the same stage to keep them aligned.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rgb <= CLR_BLACK;
      hs  <= SYNC_IDLE;
      vs  <= SYNC_IDLE;
    end else begin
      rgb <= pick;
      hs  <= hsync_in;
      vs  <= vsync_in;
    end
  end

endmodule

// File: rtl/game_director.sv
// Chip Invaders game state core: frame tick, game FSM with score/lives/wave
// bookkeeping, and the registered VGA compositor.
module game_director
  import game_director_pkg::*;
#(
  parameter int                     N_LAYERS         = 4,
  parameter logic [N_LAYERS*12-1:0] LAYER_RGB        = DEFAULT_LAYER_RGB,
  parameter rgb12_t                 BG_RGB           = CLR_BLACK,
  parameter int                     LIVES_INIT       = 3,
  parameter int                     LIVES_W          = 2,
  parameter int                     SCORE_W          = 8,
  parameter int                     WAVE_W           = 4,
  parameter int                     HIT_PAUSE_FRAMES = 60,
  parameter int                     OVER_HOLD_FRAMES = 120,
  parameter logic                   SYNC_IDLE        = 1'b1
) (
  input logic             clk,
  input logic             rst_n,
  game_director_if.slave  bus
);

  localparam int FC_W  = $clog2(max_int(HIT_PAUSE_FRAMES, OVER_HOLD_FRAMES) + 1);
  localparam int SUM_W = max_int(SCORE_W + 1, 9);
  localparam logic [FC_W-1:0]    PAUSE_LAST = FC_W'(HIT_PAUSE_FRAMES - 1);
  localparam logic [FC_W-1:0]    OVER_LAST  = FC_W'(OVER_HOLD_FRAMES - 1);
  localparam logic [SCORE_W-1:0] SCORE_MAX  = '1;

  game_state_t         state_q;
  logic                play_en_q;
  logic                frame_tick_q;
  logic                vsync_prev;
  logic [LIVES_W-1:0]  lives_q;
  logic [SCORE_W-1:0]  score_q;
  logic [WAVE_W-1:0]   wave_q;
  logic [FC_W-1:0]     frame_cnt;
  logic [SUM_W-1:0]    score_sum;
  logic [SCORE_W-1:0]  score_sat;
  logic                blink;
  rgb12_t              mix_rgb;

  // Saturating score add, widened so the carry out of the top bit is visible.
  always_comb begin
    score_sum = SUM_W'(score_q) + SUM_W'(bus.hit_points);
    score_sat = (score_sum > SUM_W'(SCORE_MAX)) ? SCORE_MAX : score_sum[SCORE_W-1:0];
  end

  // One-clock frame tick on each rising vsync; prev starts high so release is quiet.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_prev   <= 1'b1;
      frame_tick_q <= 1'b0;
    end else begin
      vsync_prev   <= bus.vsync_in;
      frame_tick_q <= bus.vsync_in & ~vsync_prev;
    end
  end

  // Game FSM with score, lives, wave and the per-state frame counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ATTRACT;
      play_en_q <= 1'b0;
      lives_q   <= '0;
      score_q   <= '0;
      wave_q    <= '0;
      frame_cnt <= '0;
    end else begin
      case (state_q)
        ATTRACT: begin
          if (frame_tick_q && bus.btn_start) begin
            state_q   <= PLAYING;
            play_en_q <= 1'b1;
            lives_q   <= LIVES_W'(LIVES_INIT);
            score_q   <= '0;
            wave_q    <= '0;
            frame_cnt <= '0;
          end
        end
        PLAYING: begin
          if (bus.alien_hit) score_q <= score_sat;
          if (bus.wave_cleared) wave_q <= wave_q + 1'b1;
          if (bus.player_hit) begin
            lives_q   <= (lives_q != '0) ? lives_q - 1'b1 : '0;
            frame_cnt <= '0;
            play_en_q <= 1'b0;
            state_q   <= (lives_q <= LIVES_W'(1)) ? GAME_OVER : HIT_PAUSE;
          end
        end
        HIT_PAUSE: begin
          if (frame_tick_q) begin
            if (frame_cnt == PAUSE_LAST) begin
              state_q   <= PLAYING;
              play_en_q <= 1'b1;
              frame_cnt <= '0;
            end else begin
              frame_cnt <= frame_cnt + 1'b1;
            end
          end
        end
        GAME_OVER: begin
          if (frame_tick_q) begin
            if (frame_cnt == OVER_LAST) begin
              state_q   <= ATTRACT;
              frame_cnt <= '0;
            end else begin
              frame_cnt <= frame_cnt + 1'b1;
            end
          end
        end
      endcase
    end
  end

  // Cannon blinks during the hit pause, following bit 3 of the frame counter.
  always_comb begin
    blink = (state_q == HIT_PAUSE) && ((frame_cnt & FC_W'(8)) != '0);
  end

  layer_mixer #(
    .N_LAYERS  (N_LAYERS),
    .LAYER_RGB (LAYER_RGB),
    .BG_RGB    (BG_RGB),
    .SYNC_IDLE (SYNC_IDLE)
  ) u_mixer (
    .clk        (clk),
    .rst_n      (rst_n),
    .display_on (bus.display_on),
    .layer_on   (bus.layer_on),
    .mask_top   (blink),
    .hsync_in   (bus.hsync_in),
    .vsync_in   (bus.vsync_in),
    .rgb        (mix_rgb),
    .hs         (bus.vga_hs),
    .vs         (bus.vga_vs)
  );

  assign bus.state      = state_q;
  assign bus.play_en    = play_en_q;
  assign bus.frame_tick = frame_tick_q;
  assign bus.lives      = lives_q;
  assign bus.score      = score_q;
  assign bus.wave       = wave_q;
  assign bus.vga_r      = mix_rgb.r;
  assign bus.vga_g      = mix_rgb.g;
  assign bus.vga_b      = mix_rgb.b;

endmodule

// File: tb/tb_game_director.sv
// Testbench for game_director: directed game sequences, a colour vector table
// and a randomized session, all compared against a rule-level model.
module tb_game_director;
  import game_director_pkg::*;

  localparam int NL = 4;
  localparam logic [11:0] BG = 12'h00F;
  localparam logic [NL*12-1:0] LRGB = {12'hF00, 12'hFFF, 12'hF0F, 12'h0F0};
  localparam int LIVES_INIT = 3;
  localparam int PAUSE_FR = 60;
  localparam int OVER_FR = 120;

  logic [11:0] colours [NL] = '{12'h0F0, 12'hF0F, 12'hFFF, 12'hF00};

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  game_director_if #(.N_LAYERS(NL), .LIVES_W(2), .SCORE_W(8), .WAVE_W(4)) gif ();

  game_director #(
    .N_LAYERS(NL), .LAYER_RGB(LRGB), .BG_RGB(BG), .LIVES_INIT(LIVES_INIT),
    .LIVES_W(2), .SCORE_W(8), .WAVE_W(4), .HIT_PAUSE_FRAMES(PAUSE_FR),
    .OVER_HOLD_FRAMES(OVER_FR), .SYNC_IDLE(1'b1)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (gif)
  );

  int n_checks = 0;
  int n_pass = 0;

  // Rule-level model of the game and the video path
  int m_state, m_lives, m_score, m_wave, m_ticks;
  bit m_tick, m_vsprev, m_hs, m_vs;
  logic [11:0] m_rgb;

  typedef struct {
    bit disp;
    logic [3:0] lay;
    bit hs;
    bit vs;
    logic [11:0] rgb;
  } mix_vec_t;
  mix_vec_t vecs [7];

  task automatic check_output(input string name, input int actual, input int expected);
    n_checks++;
    if (actual == expected) n_pass++;
    else $display("[TB] FAIL %s: actual=%0h required=%0h (t=%0t)", name, actual, expected, $time);
  endtask

  task automatic model_reset();
    m_state = 0; m_lives = 0; m_score = 0; m_wave = 0; m_ticks = 0;
    m_tick = 0; m_vsprev = 1; m_hs = 1; m_vs = 1; m_rgb = 12'h000;
  endtask

  task automatic check_reset(input string tag);
    check_output({tag, "_state"}, int'(gif.state), 0);
    check_output({tag, "_lives"}, int'(gif.lives), 0);
    check_output({tag, "_score"}, int'(gif.score), 0);
    check_output({tag, "_wave"}, int'(gif.wave), 0);
    check_output({tag, "_tick"}, int'(gif.frame_tick), 0);
    check_output({tag, "_play_en"}, int'(gif.play_en), 0);
    check_output({tag, "_rgb"}, int'({gif.vga_r, gif.vga_g, gif.vga_b}), 0);
    check_output({tag, "_hs"}, int'(gif.vga_hs), 1);
    check_output({tag, "_vs"}, int'(gif.vga_vs), 1);
  endtask

  task automatic check_model();
    check_output("state", int'(gif.state), m_state);
    check_output("lives", int'(gif.lives), m_lives);
    check_output("score", int'(gif.score), m_score);
    check_output("wave", int'(gif.wave), m_wave);
    check_output("frame_tick", int'(gif.frame_tick), int'(m_tick));
    check_output("play_en", int'(gif.play_en), (m_state == 1) ? 1 : 0);
    check_output("rgb", int'({gif.vga_r, gif.vga_g, gif.vga_b}), int'(m_rgb));
    check_output("vga_hs", int'(gif.vga_hs), int'(m_hs));
    check_output("vga_vs", int'(gif.vga_vs), int'(m_vs));
  endtask

  // One clock: advance the model with the inputs seen at the edge, then compare.
  task automatic step();
    logic [3:0] eff;
    bit tick_now;
    @(posedge clk);
    eff = gif.layer_on;
    if (m_state == 2 && ((m_ticks / 8) % 2) == 1) eff[0] = 1'b0;
    if (!gif.display_on) m_rgb = 12'h000;
    else begin
      m_rgb = BG;
      for (int i = 0; i < NL; i++) begin
        if (eff[i]) begin
          m_rgb = colours[i];
          break;
        end
      end
    end
    m_hs = gif.hsync_in;
    m_vs = gif.vsync_in;
    tick_now = m_tick;
    m_tick = gif.vsync_in && !m_vsprev;
    m_vsprev = gif.vsync_in;
    case (m_state)
      0: if (tick_now && gif.btn_start) begin
        m_state = 1; m_lives = LIVES_INIT; m_score = 0; m_wave = 0; m_ticks = 0;
      end
      1: begin
        if (gif.alien_hit) m_score = (m_score + int'(gif.hit_points) > 255) ? 255 : m_score + int'(gif.hit_points);
        if (gif.wave_cleared) m_wave = (m_wave + 1) % 16;
        if (gif.player_hit) begin
          m_lives = m_lives - 1;
          m_ticks = 0;
          m_state = (m_lives == 0) ? 3 : 2;
        end
      end
      2: if (tick_now) begin
        m_ticks++;
        if (m_ticks == PAUSE_FR) begin m_state = 1; m_ticks = 0; end
      end
      default: if (tick_now) begin
        m_ticks++;
        if (m_ticks == OVER_FR) begin m_state = 0; m_ticks = 0; end
      end
    endcase
    @(negedge clk);
    check_model();
  endtask

  task automatic apply_stimulus(input bit disp, input logic [3:0] lay, input bit hs, input bit vs);
    gif.display_on = disp;
    gif.layer_on = lay;
    gif.hsync_in = hs;
    gif.vsync_in = vs;
  endtask

  task automatic pulse_alien(input int pts);
    gif.alien_hit = 1'b1;
    gif.hit_points = 8'(pts);
    step();
    gif.alien_hit = 1'b0;
    gif.hit_points = 8'd0;
  endtask

  task automatic do_frames(input int n);
    repeat (n) begin
      gif.vsync_in = 1'b0;
      gif.hsync_in = ~gif.hsync_in;
      step();
      step();
      gif.vsync_in = 1'b1;
      gif.hsync_in = ~gif.hsync_in;
      step();
      step();
    end
  endtask

  task automatic start_game();
    gif.btn_start = 1'b1;
    gif.vsync_in = 1'b0;
    step();
    gif.vsync_in = 1'b1;
    step();
    check_output("start_tick", int'(gif.frame_tick), 1);
    step();
    check_output("start_state", int'(gif.state), 1);
    check_output("start_lives", int'(gif.lives), 3);
    check_output("start_score", int'(gif.score), 0);
    gif.btn_start = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL timeout: simulation did not complete");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    gif.hsync_in = 1'b0; gif.vsync_in = 1'b1; gif.display_on = 1'b0; gif.layer_on = '0;
    gif.btn_start = 1'b0; gif.alien_hit = 1'b0; gif.hit_points = 8'd0;
    gif.player_hit = 1'b0; gif.wave_cleared = 1'b0;
    model_reset();
    #1 rst_n = 1'b0;
    #2 check_reset("por");
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check_output("release_no_tick", int'(gif.frame_tick), 0);

    // Start, score a little, then lose a life
    $display("[TB] game start and hit pause");
    gif.display_on = 1'b1;
    gif.layer_on = 4'b0011;
    start_game();
    repeat (3) pulse_alien(10);
    gif.player_hit = 1'b1;
    step();
    gif.player_hit = 1'b0;
    check_output("hit_lives", int'(gif.lives), 2);
    check_output("hit_state", int'(gif.state), 2);
    pulse_alien(10);
    check_output("pause_score_held", int'(gif.score), 30);
    do_frames(PAUSE_FR - 1);
    check_output("pause_59", int'(gif.state), 2);
    do_frames(1);
    check_output("pause_60", int'(gif.state), 1);

    // Last life lost together with an alien hit
    $display("[TB] final life and game over");
    gif.player_hit = 1'b1;
    step();
    gif.player_hit = 1'b0;
    do_frames(PAUSE_FR);
    gif.player_hit = 1'b1;
    gif.alien_hit = 1'b1;
    gif.hit_points = 8'd5;
    step();
    gif.player_hit = 1'b0;
    gif.alien_hit = 1'b0;
    gif.hit_points = 8'd0;
    check_output("coinc_score", int'(gif.score), 35);
    check_output("coinc_lives", int'(gif.lives), 0);
    check_output("coinc_state", int'(gif.state), 3);
    pulse_alien(50);
    do_frames(OVER_FR - 1);
    check_output("over_119", int'(gif.state), 3);
    do_frames(1);
    check_output("over_120", int'(gif.state), 0);
    check_output("over_score_held", int'(gif.score), 35);

    // Saturating score and wave wrap
    $display("[TB] score saturation and wave wrap");
    start_game();
    repeat (25) pulse_alien(10);
    check_output("score_250", int'(gif.score), 250);
    pulse_alien(10);
    check_output("score_sat1", int'(gif.score), 255);
    pulse_alien(10);
    check_output("score_sat2", int'(gif.score), 255);
    pulse_alien(255);
    check_output("score_sat3", int'(gif.score), 255);
    repeat (17) begin
      gif.wave_cleared = 1'b1;
      step();
      gif.wave_cleared = 1'b0;
      step();
    end
    check_output("wave_wrap", int'(gif.wave), 1);

    // Asynchronous reset mid-game
    $display("[TB] async reset while playing");
    gif.vsync_in = 1'b0;
    step();
    #2 rst_n = 1'b0;
    gif.vsync_in = 1'b1;
    #1 check_reset("async");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check_output("async_no_tick", int'(gif.frame_tick), 0);

    // Colour/sync vector table
    $display("[TB] mixer vectors");
    vecs[0] = '{1'b1, 4'b0110, 1'b0, 1'b1, 12'hF0F};
    vecs[1] = '{1'b0, 4'b1111, 1'b1, 1'b0, 12'h000};
    vecs[2] = '{1'b1, 4'b0000, 1'b0, 1'b0, 12'h00F};
    vecs[3] = '{1'b1, 4'b1000, 1'b1, 1'b1, 12'hF00};
    vecs[4] = '{1'b1, 4'b1111, 1'b0, 1'b1, 12'h0F0};
    vecs[5] = '{1'b1, 4'b0100, 1'b1, 1'b0, 12'hFFF};
    vecs[6] = '{1'b1, 4'b1100, 1'b0, 1'b1, 12'hFFF};
    for (int v = 0; v < 7; v++) begin
      apply_stimulus(vecs[v].disp, vecs[v].lay, vecs[v].hs, vecs[v].vs);
      step();
      check_output($sformatf("vec%0d_rgb", v), int'({gif.vga_r, gif.vga_g, gif.vga_b}), int'(vecs[v].rgb));
      check_output($sformatf("vec%0d_hs", v), int'(gif.vga_hs), int'(vecs[v].hs));
      check_output($sformatf("vec%0d_vs", v), int'(gif.vga_vs), int'(vecs[v].vs));
    end

    // Randomized session against the model
    $display("[TB] random session");
    for (int c = 0; c < 6000; c++) begin
      gif.vsync_in = ((c / 8) % 2) == 1;
      gif.hsync_in = 1'($urandom_range(0, 1));
      gif.display_on = ($urandom_range(0, 7) != 0);
      gif.layer_on = 4'($urandom);
      gif.btn_start = ($urandom_range(0, 3) != 0);
      gif.alien_hit = ($urandom_range(0, 5) == 0);
      gif.hit_points = 8'($urandom);
      gif.player_hit = ($urandom_range(0, 149) == 0);
      gif.wave_cleared = ($urandom_range(0, 19) == 0);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
